// File: rtl/ro_entropy_reader_pkg.sv
// Shared types and default constants for the ring-oscillator entropy reader.
package ro_pkg;

  // Von Neumann pair tracker: nothing held, or the first bit of a pair held.
  typedef enum logic {
    PAIR_EMPTY = 1'b0,
    PAIR_HALF  = 1'b1
  } pair_state_t;

  localparam int RO_FIFO_DEPTH_DEF = 4;
  localparam int RO_RCT_CUTOFF_DEF = 32;

endpackage

// File: rtl/ro_entropy_reader_fifo.sv
// Byte FIFO: circular buffer with wrap-around pointers and a level counter.
// A push into a full FIFO is accepted only when a pop happens the same cycle.
module ro_byte_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign level_o = level_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  // Storage write; contents need no reset because the level gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and level bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ro_entropy_reader.sv
// Entropy reader: repetition-count health test, optional von Neumann
// debiaser (compiled in when RO_READER_VN_EN is defined), byte packer and
// byte FIFO behind a valid/ready output.
module ro_entropy_reader
  import ro_pkg::*;
#(
  parameter int FIFO_DEPTH = RO_FIFO_DEPTH_DEF,
  parameter int RCT_CUTOFF = RO_RCT_CUTOFF_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          health_clr,
  output logic [7:0]                    byte_out,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          health_fail
);

  logic [7:0] run_q, run_d, run_inc;
  logic       prev_q, prev_d;
  logic       fail_q, fail_d;
  logic       ovf_q, ovf_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
`ifdef RO_READER_VN_EN
  pair_state_t pair_q, pair_d;
  logic        pbit_q, pbit_d;
`endif

  logic       accept;
  logic       pack_vld;
  logic       pack_bit;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign accept      = enable && bit_valid && !fail_q && !health_clr;
  assign pop         = byte_ready && !fifo_empty;
  assign byte_valid  = !fifo_empty;
  assign overflow    = ovf_q;
  assign health_fail = fail_q;
  assign run_inc     = (run_q != 8'd0 && bit_in == prev_q) ? run_q + 8'd1 : 8'd1;
  assign push_data   = {shift_q, pack_bit};

  // Next-state: clear, RCT update, debias, pack and overflow detection.
  always_comb begin
    run_d    = run_q;
    prev_d   = prev_q;
    fail_d   = fail_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
`ifdef RO_READER_VN_EN
    pair_d   = pair_q;
    pbit_d   = pbit_q;
`endif
    pack_vld = 1'b0;
    pack_bit = bit_in;
    push     = 1'b0;

    if (health_clr) begin
      run_d   = 8'd0;
      fail_d  = 1'b0;
      ovf_d   = 1'b0;
      cnt_d   = 3'd0;
      shift_d = 7'd0;
`ifdef RO_READER_VN_EN
      pair_d  = PAIR_EMPTY;
`endif
    end else if (accept) begin
      run_d  = run_inc;
      prev_d = bit_in;
      if (run_inc == 8'(RCT_CUTOFF)) begin
        // Tripping bit is discarded and all partial state is flushed.
        fail_d  = 1'b1;
        cnt_d   = 3'd0;
        shift_d = 7'd0;
`ifdef RO_READER_VN_EN
        pair_d  = PAIR_EMPTY;
`endif
      end else begin
`ifdef RO_READER_VN_EN
        if (pair_q == PAIR_EMPTY) begin
          pair_d = PAIR_HALF;
          pbit_d = bit_in;
        end else begin
          // 01 -> 0, 10 -> 1: the output is the first bit of an unequal pair.
          pair_d   = PAIR_EMPTY;
          pack_vld = (pbit_q != bit_in);
          pack_bit = pbit_q;
        end
`else
        pack_vld = 1'b1;
`endif
      end
    end

    if (pack_vld) begin
      shift_d = {shift_q[5:0], pack_bit};
      if (cnt_q == 3'd7) begin
        push  = 1'b1;
        cnt_d = 3'd0;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end

    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // State registers for the health test, packer and debiaser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 8'd0;
      prev_q  <= 1'b0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= 3'd0;
      shift_q <= 7'd0;
`ifdef RO_READER_VN_EN
      pair_q  <= PAIR_EMPTY;
      pbit_q  <= 1'b0;
`endif
    end else begin
      run_q   <= run_d;
      prev_q  <= prev_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
`ifdef RO_READER_VN_EN
      pair_q  <= pair_d;
      pbit_q  <= pbit_d;
`endif
    end
  end

  ro_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i (push_data),
    .pop_i  (pop),
    .data_o (byte_out),
    .level_o(fifo_level),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_ro_entropy_reader.sv
// Bench for ro_entropy_reader: a behavioural reference model pushes expected
// bytes to a scoreboard as bits are driven; bytes are popped and compared as
// the DUT hands them out. Works in both builds (RO_READER_VN_EN on or off).
module tb_ro_entropy_reader;

  localparam int DEPTH = 4;
  localparam int CUT   = 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          health_clr = 1'b0;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          health_fail;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] sb[$];
  int         m_level;
  int         m_run;
  logic       m_prev;
  logic       m_fail;
  logic       m_ovf;
  logic       m_half;
  logic       m_pb;
  int         m_cnt;
  logic [7:0] m_acc;

  always #5 clk = ~clk;

  ro_entropy_reader #(
    .FIFO_DEPTH(DEPTH),
    .RCT_CUTOFF(CUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .health_clr (health_clr),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .health_fail(health_fail)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_level = 0; m_run = 0; m_prev = 1'b0; m_fail = 1'b0; m_ovf = 1'b0;
    m_half = 1'b0; m_pb = 1'b0; m_cnt = 0; m_acc = 8'h00;
  endtask

  task automatic post_check();
    logic [7:0] head;
    head = (m_level > 0) ? sb[0] : 8'h00;
    check_eq("level", 32'(fifo_level), 32'(m_level));
    check_eq("valid", 32'(byte_valid), 32'(m_level > 0));
    check_eq("head", 32'(byte_out), 32'(head));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("health_fail", 32'(health_fail), 32'(m_fail));
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic cyc(input logic en, input logic bv, input logic b,
                     input logic clr, input logic rdy);
    int         lvl0;
    int         nr;
    logic       popped;
    logic       pk_vld;
    logic       pk_bit;
    logic       pushed;
    logic [7:0] pdata;
    logic [7:0] exp;
    enable = en; bit_valid = bv; bit_in = b; health_clr = clr; byte_ready = rdy;
    lvl0 = m_level; popped = 1'b0; pk_vld = 1'b0; pk_bit = b; pushed = 1'b0; pdata = 8'h00;
    if (rdy && m_level > 0) begin
      exp = sb.pop_front();
      check_eq("pop_data", 32'(byte_out), 32'(exp));
      popped = 1'b1;
      m_level--;
    end
    if (clr) begin
      m_run = 0; m_fail = 1'b0; m_ovf = 1'b0; m_half = 1'b0; m_cnt = 0;
    end else if (en && bv && !m_fail) begin
      nr = (m_run != 0 && b == m_prev) ? m_run + 1 : 1;
      m_prev = b; m_run = nr;
      if (nr == CUT) begin
        m_fail = 1'b1; m_half = 1'b0; m_cnt = 0;
      end else begin
`ifdef RO_READER_VN_EN
        if (!m_half) begin
          m_half = 1'b1; m_pb = b;
        end else begin
          m_half = 1'b0;
          if (m_pb != b) begin pk_vld = 1'b1; pk_bit = m_pb; end
        end
`else
        pk_vld = 1'b1;
`endif
      end
    end
    if (pk_vld) begin
      m_acc = {m_acc[6:0], pk_bit};
      m_cnt++;
      if (m_cnt == 8) begin pushed = 1'b1; pdata = m_acc; m_cnt = 0; end
    end
    if (pushed) begin
      if (lvl0 < DEPTH || popped) begin
        sb.push_back(pdata);
        m_level++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    post_check();
  endtask

  // Feed one byte MSB first; in the debiased build each bit becomes a pair (b, ~b).
  task automatic send_byte(input logic [7:0] v, input logic rdy_last);
    for (int i = 7; i >= 0; i--) begin
`ifdef RO_READER_VN_EN
      cyc(1'b1, 1'b1, v[i], 1'b0, 1'b0);
      cyc(1'b1, 1'b1, ~v[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
`else
      cyc(1'b1, 1'b1, v[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
`endif
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("drained", 32'(byte_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    health_clr = 1'b0; byte_ready = 1'b0;
    model_reset();
    #1;
    post_check();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a1;
    a1 = 8'hA1;
    model_reset();
    #2;
    do_reset();

    // Basic byte and drain
    send_byte(a1, 1'b0);
    check_eq("a1_head", 32'(byte_out), 32'h0A1);
    drain();

`ifdef RO_READER_VN_EN
    // Debias pattern 0,1,1,0 x4 -> 8'h55
    for (int r = 0; r < 4; r++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_eq("vn55_out", 32'(byte_out), 32'h55);
    check_eq("vn55_lvl", 32'(fifo_level), 32'd1);
    drain();
    // Same pattern with 00 and 11 pairs interleaved
    for (int r = 0; r < 4; r++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    check_eq("vnmix_out", 32'(byte_out), 32'h55);
    check_eq("vnmix_lvl", 32'(fifo_level), 32'd1);
    drain();
`endif

    // Enable low holds partial state
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, a1[7-i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 3; i < 8; i++) cyc(1'b1, 1'b1, a1[7-i], 1'b0, 1'b0);
    drain();

    // FIFO overflow: 5 bytes into depth 4, then drain in order
    for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0);
    check_eq("ovf_lvl", 32'(fifo_level), 32'd4);
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    drain();

    // Health failure: 32 identical bits
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < CUT; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("hf_set", 32'(health_fail), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("hf_clr", 32'(health_fail), 32'd0);
    drain();
    send_byte(a1, 1'b0);
    drain();

    // Reset mid-byte
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, a1[7-i], 1'b0, 1'b0);
    do_reset();
    send_byte(a1, 1'b0);
    check_eq("rst_a1", 32'(byte_out), 32'h0A1);
    drain();

    // Simultaneous push and pop on a full FIFO
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(8'(8'h10 + k), 1'b0);
    send_byte(8'h3C, 1'b1);
    check_eq("simul_lvl", 32'(fifo_level), 32'd4);
    check_eq("simul_ovf", 32'(overflow), 32'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ro_entropy_reader.md
# ro_entropy_reader

Consumer end of the ring-oscillator entropy path: accepts the sampled XOR bit stream one bit per cycle and applies a repetition-count health test. It optionally debiases the stream (von Neumann), packs the surviving bits into bytes and buffers them in a small FIFO behind a valid/ready output. It sits between the RO sampling stage and whatever block consumes random bytes, and replaces byte-select readout with a flow-controlled stream.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO depth; power of two, at least 2.
- `RCT_CUTOFF`, default 32: run length of identical raw bits that trips the health test; range 2..255.
- `clk` input, 1 bit: single clock; all state on rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `enable` input, 1 bit: when high, raw bits are accepted.
- `bit_in` input, 1 bit: raw sampled entropy bit.
- `bit_valid` input, 1 bit: `bit_in` is valid this cycle.
- `health_clr` input, 1 bit: clears `health_fail` and restarts collection.
- `byte_out` output, 8 bits: FIFO head; 8'h00 when FIFO empty.
- `byte_valid` output, 1 bit: FIFO not empty.
- `byte_ready` input, 1 bit: consumer takes the head when `byte_valid && byte_ready`.
- `fifo_level` output, $clog2(FIFO_DEPTH)+1 bits: bytes currently stored.
- `overflow` output, 1 bit: sticky; a completed byte was dropped because the FIFO was full.
- `health_fail` output, 1 bit: sticky repetition-count failure.

## Operation
- **Accept condition.** A bit is accepted when `enable && bit_valid && !health_fail && !health_clr`.
  - With `enable` low, all partial state (pair, packer, RCT run) is held, not cleared.
- **Repetition-count test (RCT)** on accepted raw bits:
  - Run counter is 1 on the first bit after reset or clear.
  - It increments when a bit equals the previous bit; it resets to 1 otherwise.
  - When the counter reaches `RCT_CUTOFF`, `health_fail` sets at that edge.
  - The tripping bit is discarded, and the pair state and partial byte are flushed.
- **Debiaser.** Two-state FSM: `PAIR_EMPTY` and `PAIR_HALF` (first bit stored).
  - On the second bit, the pair 01 yields 0 and 10 yields 1; 00 and 11 yield nothing.
  - The FSM returns to `PAIR_EMPTY` after every second bit.
- **Packer.** 3-bit count plus 7-bit shift register, shifting left, so the first packed bit lands in `byte_out[7]`.
  - The 8th bit completes the byte: `{shift[6:0], bit}` is pushed into the FIFO and the count wraps to 0.
- **FIFO** is a circular buffer with wrap-around pointers.
  - A push when full is dropped and sets `overflow`, unless a pop occurs the same cycle. Simultaneous push and pop when full is accepted and the level is unchanged.
  - Simultaneous push and pop when empty: the pushed byte is stored, and `byte_valid` rises the next cycle.
- **`health_clr`** (single cycle, any time):
  - clears `health_fail`, `overflow`, the RCT run, the pair FSM and the packer;
  - leaves FIFO contents intact;
  - any bit offered that same cycle is ignored.
- **Reset:**
  - all outputs 0, FIFO empty, `fifo_level` 0;
  - FSM in `PAIR_EMPTY`, packer count 0;
  - reset mid-byte discards the partial byte.

## Timing
- Bit acceptance, RCT update, debias and pack all complete in the accepting edge; there is no input pipeline.
- A byte completed at edge T is in the FIFO after T. `byte_valid`, `byte_out` and `fifo_level` reflect it in the cycle following T (1-cycle latency).
- A pop at edge T presents the next head after T. Sustained throughput is 1 byte per cycle at the FIFO output.
- `health_fail` and `overflow` are visible in the cycle after the triggering edge.

## Configuration
- `RO_READER_VN_EN` defined: the von Neumann debiaser is compiled in, as described above.
- `RO_READER_VN_EN` undefined: the debiaser is removed and every accepted, non-tripping raw bit goes straight to the packer, giving 8 accepted bits per byte.
- The RCT and FIFO behave identically in both builds.

## Structure
- Shared package `ro_pkg` holds:
  - the debiaser state typedef (`PAIR_EMPTY`, `PAIR_HALF`);
  - default constants `RO_FIFO_DEPTH_DEF = 4` and `RO_RCT_CUTOFF_DEF = 32`.
- One sub-module, `ro_byte_fifo`, parameterised by depth: synchronous push/pop, level, full/empty. Overflow flag logic stays in the top.

## Test plan
- **Debias pattern.** VN build, `byte_ready`=0; feed raw 0,1,1,0 repeated 4 times (16 bits) → `byte_out`=8'h55, `byte_valid`=1 and `fifo_level`=1 in the cycle after the 16th bit.
- **Discarded pairs.** VN build; interleave pairs 00 and 11 between the 01/10 pairs of the previous scenario → still exactly 8'h55, and no extra bytes.
- **FIFO overflow.** Depth 4, `byte_ready`=0; produce 5 bytes 8'h01..8'h05 (non-VN build) → `fifo_level`=4 and `overflow`=1. Then drain with `byte_ready`=1 → 8'h01..8'h04 in order, then `byte_valid`=0.
- **Health failure.** Non-VN build; feed 32 consecutive 1s → `health_fail`=1 after the 32nd bit and 3 bytes 8'hFF stored; further bits produce nothing. Pulse `health_clr` → `health_fail`=0, and 8 new bits 8'hA1 produce 8'hA1.
- **Reset mid-byte.** Non-VN build; feed 5 bits, then pull `rst_n` low → all outputs 0 immediately. After release, 8 bits 1,0,1,0,0,0,0,1 → 8'hA1.
- **Simultaneous push and pop.** FIFO full, `byte_ready`=1 on the cycle a byte completes → level stays 4, `overflow` stays 0.
